// File: rtl/craps_game_ctrl.sv
// rtl/craps_game_ctrl.sv - two-die craps controller: live dice, roll capture, come-out/point rules, tallies
// Dice free-run; a synchronised roll press captures them (or test values) and plays one craps roll.
module craps_game_ctrl #(
  parameter int SIDES   = 6,
  parameter int DIE_W   = 4,
  parameter int SUM_W   = 5,
  parameter int SCORE_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               roll,
  input  logic               clr_score,
  input  logic               test_en,
  input  logic [DIE_W-1:0]   test_a,
  input  logic [DIE_W-1:0]   test_b,
  output logic [DIE_W-1:0]   die_a,
  output logic [DIE_W-1:0]   die_b,
  output logic [DIE_W-1:0]   roll_a,
  output logic [DIE_W-1:0]   roll_b,
  output logic [SUM_W-1:0]   roll_sum,
  output logic [SUM_W-1:0]   point,
  output logic [1:0]         state,
  output logic               win,
  output logic               loss,
  output logic [SCORE_W-1:0] wins,
  output logic [SCORE_W-1:0] losses
);

  typedef enum logic [1:0] {
    COMEOUT  = 2'b00,
    POINT_ST = 2'b01,
    WIN_ST   = 2'b10,
    LOSE_ST  = 2'b11
  } state_t;

  localparam logic [DIE_W-1:0]   DIE_ONE   = DIE_W'(1);
  localparam logic [DIE_W-1:0]   DIE_MAX   = DIE_W'(SIDES);
  localparam logic [SUM_W-1:0]   NAT       = SUM_W'(SIDES + 1);
  localparam logic [SUM_W-1:0]   YO        = SUM_W'(2 * SIDES - 1);
  localparam logic [SUM_W-1:0]   BOX       = SUM_W'(2 * SIDES);
  localparam logic [SUM_W-1:0]   TWO       = SUM_W'(2);
  localparam logic [SUM_W-1:0]   THREE     = SUM_W'(3);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             cur_st, st_next;
  logic [SUM_W-1:0]   pt_next;
  logic               win_next, loss_next;
  logic [SCORE_W-1:0] wins_next, losses_next;
  logic               s1, s2, s3, roll_pulse;
  logic [DIE_W-1:0]   cap_a, cap_b;
  logic [SUM_W-1:0]   sum;

  assign state = cur_st;

  // die_b steps only when die_a wraps, so the pair walks all SIDES*SIDES combinations
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      die_a <= DIE_ONE;
      die_b <= DIE_ONE;
    end else begin
      die_a <= (die_a == DIE_MAX) ? DIE_ONE : die_a + DIE_ONE;
      if (die_a == DIE_MAX)
        die_b <= (die_b == DIE_MAX) ? DIE_ONE : die_b + DIE_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= roll;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign roll_pulse = s2 & ~s3;
  assign cap_a      = test_en ? test_a : die_a;
  assign cap_b      = test_en ? test_b : die_b;
  assign sum        = SUM_W'(cap_a) + SUM_W'(cap_b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_st   <= COMEOUT;
      point    <= '0;
      roll_a   <= DIE_ONE;
      roll_b   <= DIE_ONE;
      roll_sum <= '0;
      win      <= 1'b0;
      loss     <= 1'b0;
      wins     <= '0;
      losses   <= '0;
    end else begin
      cur_st <= st_next;
      point  <= pt_next;
      win    <= win_next;
      loss   <= loss_next;
      wins   <= wins_next;
      losses <= losses_next;
      if (roll_pulse) begin
        roll_a   <= cap_a;
        roll_b   <= cap_b;
        roll_sum <= sum;
      end
    end
  end

  // A finished game (WIN/LOSE) treats the next press as a fresh come-out roll
  always_comb begin
    st_next = cur_st;
    pt_next = point;
    if (roll_pulse) begin
      if (cur_st == POINT_ST) begin
        if (sum == point) begin
          st_next = WIN_ST;
          pt_next = '0;
        end else if (sum == NAT) begin
          st_next = LOSE_ST;
          pt_next = '0;
        end
      end else begin
        if (sum == NAT || sum == YO) begin
          st_next = WIN_ST;
          pt_next = '0;
        end else if (sum == TWO || sum == THREE || sum == BOX) begin
          st_next = LOSE_ST;
          pt_next = '0;
        end else begin
          st_next = POINT_ST;
          pt_next = sum;
        end
      end
    end
  end

  // Clear takes priority over a same-edge tally increment
  always_comb begin
    win_next    = (st_next == WIN_ST);
    loss_next   = (st_next == LOSE_ST);
    wins_next   = wins;
    losses_next = losses;
    if (clr_score) begin
      wins_next   = '0;
      losses_next = '0;
    end else if (roll_pulse) begin
      if (st_next == WIN_ST && wins != SCORE_MAX)
        wins_next = wins + SCORE_W'(1);
      if (st_next == LOSE_ST && losses != SCORE_MAX)
        losses_next = losses + SCORE_W'(1);
    end
  end

endmodule

// File: tb/tb_craps_game_ctrl.sv
// tb/tb_craps_game_ctrl.sv - scoreboard bench for craps_game_ctrl with a rules-level reference model
module tb_craps_game_ctrl;
  localparam int SIDES   = 6;
  localparam int DIE_W   = 4;
  localparam int SUM_W   = 5;
  localparam int SCORE_W = 3;
  localparam int SMAX    = (1 << SCORE_W) - 1;
  localparam int ST_COME = 0, ST_PT = 1, ST_WIN = 2, ST_LOSE = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               roll = 1'b0;
  logic               clr_score = 1'b0;
  logic               test_en = 1'b0;
  logic [DIE_W-1:0]   test_a = '0, test_b = '0;
  logic [DIE_W-1:0]   die_a, die_b, roll_a, roll_b;
  logic [SUM_W-1:0]   roll_sum, point;
  logic [1:0]         state;
  logic               win, loss;
  logic [SCORE_W-1:0] wins, losses;

  craps_game_ctrl #(.SIDES(SIDES), .DIE_W(DIE_W), .SUM_W(SUM_W), .SCORE_W(SCORE_W)) dut (
    .clock(clock), .reset(reset), .roll(roll), .clr_score(clr_score), .test_en(test_en),
    .test_a(test_a), .test_b(test_b), .die_a(die_a), .die_b(die_b), .roll_a(roll_a),
    .roll_b(roll_b), .roll_sum(roll_sum), .point(point), .state(state), .win(win),
    .loss(loss), .wins(wins), .losses(losses)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int ra, rb, sum, st, pt, w, l;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_ra = 1, m_rb = 1, m_sum = 0, m_st = ST_COME, m_pt = 0, m_w = 0, m_l = 0;

  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int live_a(input int n);
    return (n % SIDES) + 1;
  endfunction

  function automatic int live_b(input int n);
    return ((n / SIDES) % SIDES) + 1;
  endfunction

  function automatic rec_t reset_rec();
    rec_t r;
    r = '{due: 0, ra: 1, rb: 1, sum: 0, st: ST_COME, pt: 0, w: 0, l: 0};
    return r;
  endfunction

  task automatic compare_all(input rec_t e);
    chk("roll_a", int'(roll_a), e.ra);
    chk("roll_b", int'(roll_b), e.rb);
    chk("roll_sum", int'(roll_sum), e.sum);
    chk("state", int'(state), e.st);
    chk("point", int'(point), e.pt);
    chk("win", int'(win), int'(e.st == ST_WIN));
    chk("loss", int'(loss), int'(e.st == ST_LOSE));
    chk("wins", int'(wins), e.w);
    chk("losses", int'(losses), e.l);
  endtask

  // Monitor: live dice every cycle, registered outputs held or updated on the due cycle
  always @(negedge clock) begin
    if (!reset) begin
      cur = reset_rec();
    end else begin
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("scoreboard_due", cyc, q[0].due);
        cur = q.pop_front();
      end else if (q.size() > 0 && q[0].due == cyc) begin
        cur = q.pop_front();
      end
      chk("die_a", int'(die_a), live_a(cyc));
      chk("die_b", int'(die_b), live_b(cyc));
      compare_all(cur);
    end
  end

  function automatic rec_t snapshot(input int due);
    rec_t r;
    r = '{due: due, ra: m_ra, rb: m_rb, sum: m_sum, st: m_st, pt: m_pt, w: m_w, l: m_l};
    return r;
  endfunction

  // Reference craps rules on a rolled total s
  function automatic void play(input int s);
    bit won, lost;
    won = 0;
    lost = 0;
    if (m_st == ST_PT) begin
      if (s == m_pt) won = 1;
      else if (s == SIDES + 1) lost = 1;
    end else begin
      if (s == SIDES + 1 || s == 2 * SIDES - 1) won = 1;
      else if (s == 2 || s == 3 || s == 2 * SIDES) lost = 1;
      else begin
        m_st = ST_PT;
        m_pt = s;
      end
    end
    if (won) begin
      m_st = ST_WIN;
      m_pt = 0;
      if (m_w < SMAX) m_w++;
    end
    if (lost) begin
      m_st = ST_LOSE;
      m_pt = 0;
      if (m_l < SMAX) m_l++;
    end
  endfunction

  task automatic press(input bit ten, input int a, input int b, input int hold, input bit clr);
    int m;
    @(negedge clock);
    m = cyc;
    test_en = ten;
    test_a = DIE_W'(a);
    test_b = DIE_W'(b);
    roll = 1'b1;
    m_ra = ten ? a : live_a(m + 2);
    m_rb = ten ? b : live_b(m + 2);
    m_sum = m_ra + m_rb;
    play(m_sum);
    if (clr) begin
      m_w = 0;
      m_l = 0;
    end
    q.push_back(snapshot(m + 3));
    do begin
      @(negedge clock);
      if (cyc == m + hold) roll = 1'b0;
      clr_score = clr && (cyc == m + 2);
    end while (!(cyc >= m + hold + 3 && cyc >= m + 4));
    clr_score = 1'b0;
  endtask

  task automatic clear_only();
    @(negedge clock);
    clr_score = 1'b1;
    m_w = 0;
    m_l = 0;
    q.push_back(snapshot(cyc + 1));
    @(negedge clock);
    clr_score = 1'b0;
  endtask

  task automatic model_reset();
    m_ra = 1; m_rb = 1; m_sum = 0; m_st = ST_COME; m_pt = 0; m_w = 0; m_l = 0;
  endtask

  task automatic check_reset_values();
    chk("rst_die_a", int'(die_a), 1);
    chk("rst_die_b", int'(die_b), 1);
    compare_all(reset_rec());
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_values();
    #2 reset = 1'b1;
    repeat (20) @(negedge clock);

    press(1, 3, 4, 1, 0);
    press(1, 5, 6, 1, 0);
    press(1, 1, 1, 1, 0);
    press(1, 6, 6, 1, 0);
    press(1, 2, 2, 1, 0);
    press(1, 1, 2, 1, 0);
    press(1, 3, 1, 1, 0);
    press(1, 4, 4, 1, 0);
    press(1, 2, 5, 50, 0);
    for (int i = 0; i < 6; i++) press(1, 3, 4, 2, 0);
    press(1, 3, 4, 1, 1);
    press(1, 2, 2, 1, 0);

    @(negedge clock);
    #2 reset = 1'b0;
    model_reset();
    #1 check_reset_values();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) clear_only();
      press(bit'($urandom_range(0, 1)), $urandom_range(1, SIDES), $urandom_range(1, SIDES),
            ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 4), $urandom_range(0, 7) == 0);
    end

    repeat (5) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/craps_game_ctrl.md
Name: craps_game_ctrl

Overview:
- Parametrised successor to the two-die craps game controller.
- Runs two free-running die counters with a configurable face count, and synchronises and edge-detects the asynchronous roll button.
- Captures the dice on each press and plays full come-out/point craps rules through a registered state machine.
- Keeps saturating win/loss tallies, and provides a test-load path so dice values can be forced for verification.
- Sits between the roll pushbutton and the existing 7-segment decoders and LEDs.

Parameters:
- SIDES, 6, faces per die; legal range 4..15.
- DIE_W, 4, die value width; must satisfy 2^DIE_W > SIDES.
- SUM_W, 5, sum/point width; must satisfy 2^SUM_W > 2*SIDES.
- SCORE_W, 8, width of each win/loss tally.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- roll  in  1  asynchronous roll button, active high.
- clr_score  in  1  synchronous clear of both tallies.
- test_en  in  1  when 1, a roll captures test_a/test_b instead of the live counters.
- test_a  in  DIE_W  forced die A value; legal 1..SIDES.
- test_b  in  DIE_W  forced die B value; legal 1..SIDES.
- die_a  out  DIE_W  live die A counter, feeds a display decoder.
- die_b  out  DIE_W  live die B counter.
- roll_a  out  DIE_W  captured die A of the last roll.
- roll_b  out  DIE_W  captured die B of the last roll.
- roll_sum  out  SUM_W  roll_a + roll_b, registered.
- point  out  SUM_W  established point; 0 when none.
- state  out  2  COMEOUT=00, POINT=01, WIN=10, LOSE=11.
- win  out  1  high while state==WIN.
- loss  out  1  high while state==LOSE.
- wins  out  SCORE_W  count of games won.
- losses  out  SCORE_W  count of games lost.

Behaviour:
- Reset (reset==0, asynchronous) sets:
  - die_a = die_b = 1, roll_a = roll_b = 1;
  - roll_sum = 0, point = 0, state = COMEOUT;
  - win = loss = 0, wins = losses = 0;
  - sync flops = 0.
- Dice counters:
  - die_a advances 1..SIDES every clock, wrapping SIDES->1.
  - die_b advances only on the cycle die_a wraps, also 1..SIDES.
  - Counters run continuously in all states.
- Roll detection:
  - roll passes through a 2-flop synchroniser (s1, s2) plus a delay flop s3.
  - roll_pulse = s2 & ~s3.
  - If roll is first sampled high at edge k, roll_pulse is high between edges k+1 and k+2, and all game registers update at edge k+2.
  - Holding roll high produces exactly one pulse; a new roll needs a low of at least 2 clocks.
- Capture on roll_pulse:
  - roll_a/roll_b <= (test_en ? test_a/test_b : die_a/die_b).
  - roll_sum <= the zero-extended sum of those values.
  - Game evaluation uses that same-cycle sum S.
- Define: NAT = SIDES+1, YO = 2*SIDES-1, BOX = 2*SIDES.
- Transitions occur only on roll_pulse:
  - COMEOUT:
    - S==NAT or S==YO -> WIN.
    - S==2, S==3 or S==BOX -> LOSE.
    - Otherwise -> POINT with point <= S.
  - POINT:
    - S==point -> WIN.
    - S==NAT -> LOSE.
    - Otherwise remain in POINT; point unchanged.
  - WIN or LOSE: the press starts a new game. point <= 0 and the roll is evaluated as a COMEOUT roll in the same edge.
- On entering WIN, point <= 0. On entering LOSE, point <= 0.
- win/loss are registered decodes of state. They are never both high.
- Tallies:
  - +1 on every transition into WIN (wins) or into LOSE (losses), including WIN->WIN and LOSE->LOSE through a new game.
  - Saturate at 2^SCORE_W-1.
- clr_score:
  - Zeroes both tallies on the next edge.
  - If coincident with a roll_pulse that ends a game, the clear wins and the tally stays 0.
  - Does not affect state.
- Without roll_pulse, all game registers hold.
- Reset asserted mid-game aborts immediately to the reset values. A roll pulse in the reset-release cycle is discarded because the sync flops are cleared.
- test_a/test_b values outside 1..SIDES are illegal stimulus; behaviour is unspecified.

Test Plan:
- Reset, release, idle 20 clocks -> die_a cycles 1..6 then wraps to 1; die_b increments once per die_a wrap. state=00, point=0, win=loss=0.
- test_en=1; press with (3,4), then press with (5,6) -> first press: roll_sum=7, state=WIN, wins=1, edge k+2 latency. Second press (new game, S=11) -> WIN, wins=2.
- Press (1,1) -> state=LOSE, losses=1. Next press (6,6) -> LOSE, losses=2, point=0.
- Press (2,2) -> POINT, point=4. Press (1,2) -> stays POINT, point=4. Press (3,1) -> WIN, point=0, wins+1.
- Press (4,4) -> POINT, point=8. Press (2,5) -> LOSE; hold roll high 50 clocks -> exactly one evaluation.
- SCORE_W=2: force 5 wins -> wins saturates at 3. Assert clr_score on the same edge as a winning pulse -> wins=0, state=WIN. Assert reset while in POINT -> all outputs return to reset values asynchronously.
